// File: rtl/tile_pkg.sv
// -----------------------------------------------------------------------------
// tile_pkg
// Shared geometry, storage sizes and FSM state type for the tile-map store.
// No ports (package).
// -----------------------------------------------------------------------------
package tile_pkg;

  localparam int N_PER_ROW      = 60;   // tiles per screen row
  localparam int N_PER_COL      = 34;   // tile rows (33.75 rounded up)
  localparam int SPRITE_IDX_W   = 4;    // bits per tile sprite index
  localparam int TILES_PER_WORD = 8;    // tiles packed per storage word
  localparam int WORD_ADDR_W    = 8;    // width of packed word index
  localparam int COORD_W        = 6;    // width of row/col coordinates
  localparam int DATA_W         = SPRITE_IDX_W * TILES_PER_WORD;

  // ceil(60*34/8): 2040 tiles fill exactly 255 words.
  localparam int TILE_WORDS     = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } tile_state_t;

endpackage

// File: rtl/tile_map_store_if.sv
// -----------------------------------------------------------------------------
// tile_map_store_if
// Bundles the tile-map read port, tile write handshake and clear control.
// Modports:
//   slave  - the tile-map store (drives sprite_addr, wr_ready, wr_err, busy)
//   master - pixel generator / game logic side
// With TILEMAP_READBACK_EN defined, adds rd2_row/rd2_col/rd2_sprite for
// single-tile inspection.
// -----------------------------------------------------------------------------
interface tile_map_store_if;
  import tile_pkg::*;

  logic [WORD_ADDR_W-1:0]  rd_word;
  logic [DATA_W-1:0]       sprite_addr;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [COORD_W-1:0]      wr_row;
  logic [COORD_W-1:0]      wr_col;
  logic [SPRITE_IDX_W-1:0] wr_sprite;
  logic                    wr_err;

  logic                    clr_start;
  logic [SPRITE_IDX_W-1:0] clr_sprite;
  logic                    busy;

`ifdef TILEMAP_READBACK_EN
  logic [COORD_W-1:0]      rd2_row;
  logic [COORD_W-1:0]      rd2_col;
  logic [SPRITE_IDX_W-1:0] rd2_sprite;
`endif

  modport slave (
    input  rd_word, wr_valid, wr_row, wr_col, wr_sprite, clr_start, clr_sprite,
    output sprite_addr, wr_ready, wr_err, busy
`ifdef TILEMAP_READBACK_EN
    , input rd2_row, rd2_col
    , output rd2_sprite
`endif
  );

  modport master (
    output rd_word, wr_valid, wr_row, wr_col, wr_sprite, clr_start, clr_sprite,
    input  sprite_addr, wr_ready, wr_err, busy
`ifdef TILEMAP_READBACK_EN
    , output rd2_row, rd2_col
    , input  rd2_sprite
`endif
  );

endinterface

// File: rtl/tile_addr_calc.sv
// -----------------------------------------------------------------------------
// tile_addr_calc
// Combinational (row, col) -> (storage word, nibble within word) mapping.
// Ports:
//   row, col  in   tile coordinates
//   word      out  packed word index (tile_idx >> 3)
//   nibble    out  tile position inside the word (tile_idx[2:0])
//   in_range  out  row < N_PER_COL and col < N_PER_ROW
// word/nibble are meaningless when in_range is low.
// -----------------------------------------------------------------------------
module tile_addr_calc
  import tile_pkg::*;
(
  input  logic [COORD_W-1:0]     row,
  input  logic [COORD_W-1:0]     col,
  output logic [WORD_ADDR_W-1:0] word,
  output logic [2:0]             nibble,
  output logic                   in_range
);

  // 11 bits covers every in-range index (max 2039); out-of-range results
  // may wrap, which is harmless because in_range gates their use.
  logic [10:0] tile_idx;

  assign tile_idx = 11'(row) * 11'(N_PER_ROW) + 11'(col);
  assign word     = tile_idx[10:3];
  assign nibble   = tile_idx[2:0];
  assign in_range = (row < COORD_W'(N_PER_COL)) && (col < COORD_W'(N_PER_ROW));

endmodule

// File: rtl/tile_map_store.sv
// -----------------------------------------------------------------------------
// tile_map_store
// Tile-map memory: 255 words of eight 4-bit sprite indices. Serves the pixel
// generator's packed-word read port, accepts single-tile writes over a
// valid/ready handshake and runs a full-map clear engine.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  tile_map_store_if.slave:
//          rd_word -> sprite_addr   registered read, 1-cycle latency
//          wr_valid/wr_ready/wr_row/wr_col/wr_sprite/wr_err  tile write
//          clr_start/clr_sprite/busy                          map clear
// Optional: define TILEMAP_READBACK_EN to add the rd2_row/rd2_col ->
// rd2_sprite single-tile readback port.
// -----------------------------------------------------------------------------
module tile_map_store
  import tile_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  tile_map_store_if.slave bus
);

  tile_state_t             state_q, state_d;
  logic [WORD_ADDR_W-1:0]  clr_cnt;
  logic [SPRITE_IDX_W-1:0] fill_q;

  logic [DATA_W-1:0]       mem [TILE_WORDS];

  logic [WORD_ADDR_W-1:0]  wr_word;
  logic [2:0]              wr_nibble;
  logic                    wr_in_range;
  logic                    wr_fire;

  tile_addr_calc u_wr_addr (
    .row      (bus.wr_row),
    .col      (bus.wr_col),
    .word     (wr_word),
    .nibble   (wr_nibble),
    .in_range (wr_in_range)
  );

  assign bus.wr_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == CLEAR);
  assign wr_fire      = bus.wr_valid & bus.wr_ready;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clr_start) state_d = CLEAR;
      CLEAR:   if (clr_cnt == WORD_ADDR_W'(TILE_WORDS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state, clear counter/fill latch, error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt    <= '0;
      fill_q     <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      // clr_start during CLEAR is ignored: fill and counter only load in IDLE.
      if (state_q == IDLE && bus.clr_start) begin
        clr_cnt <= '0;
        fill_q  <= bus.clr_sprite;
      end else if (state_q == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      bus.wr_err <= wr_fire & ~wr_in_range;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. A same-edge write and clr_start both land: the write updates the
  // word now and the clear overwrites it later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the map must read all-zero right after reset (including an
      // aborted clear), so the array is built from resettable flops, not RAM.
      for (int i = 0; i < TILE_WORDS; i++) mem[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem[clr_cnt] <= {TILES_PER_WORD{fill_q}};
    end else if (wr_fire && wr_in_range) begin
      mem[wr_word][wr_nibble*SPRITE_IDX_W +: SPRITE_IDX_W] <= bus.wr_sprite;
    end
  end

  // Registered read; sampling mem before its update gives read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sprite_addr <= '0;
    end else if (bus.rd_word < WORD_ADDR_W'(TILE_WORDS)) begin
      bus.sprite_addr <= mem[bus.rd_word];
    end else begin
      bus.sprite_addr <= '0;
    end
  end

`ifdef TILEMAP_READBACK_EN
  logic [WORD_ADDR_W-1:0] rd2_word;
  logic [2:0]             rd2_nibble;
  logic                   rd2_in_range;

  tile_addr_calc u_rd2_addr (
    .row      (bus.rd2_row),
    .col      (bus.rd2_col),
    .word     (rd2_word),
    .nibble   (rd2_nibble),
    .in_range (rd2_in_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd2_sprite <= '0;
    end else if (rd2_in_range) begin
      bus.rd2_sprite <= mem[rd2_word][rd2_nibble*SPRITE_IDX_W +: SPRITE_IDX_W];
    end else begin
      bus.rd2_sprite <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_tile_map_store.sv
// -----------------------------------------------------------------------------
// tb_tile_map_store
// Self-checking bench for tile_map_store. The reference keeps one sprite
// index per tile (2040 entries) and assembles expected words from it.
// -----------------------------------------------------------------------------
module tb_tile_map_store;

  localparam int ROWS   = 34;
  localparam int COLS   = 60;
  localparam int NTILES = ROWS * COLS;
  localparam int NWORDS = 255;

  logic clk;
  logic rst;

  tile_map_store_if bus ();

  tile_map_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [3:0] tiles [NTILES];
  bit         m_clearing;
  int         m_cnt;
  logic [3:0] m_fill;

  int n_cmp;
  int n_bad;
  int busy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r;
    r = '0;
    if (w < NWORDS)
      for (int i = 0; i < 8; i++) r[4*i +: 4] = tiles[w*8 + i];
    return r;
  endfunction

  function automatic bit coord_ok(input int row, input int col);
    return (row < ROWS) && (col < COLS);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTILES; i++) tiles[i] = 4'h0;
    m_clearing = 1'b0;
    m_cnt      = 0;
    m_fill     = 4'h0;
  endtask

  // One clock: predict from the pre-edge model, update the model, then compare.
  task automatic cycle(output bit acc);
    logic [31:0] e_rd;
    bit          e_err;
    bit          e_busy;
`ifdef TILEMAP_READBACK_EN
    logic [3:0]  e_rd2;
    e_rd2 = coord_ok(int'(bus.rd2_row), int'(bus.rd2_col)) ?
            tiles[int'(bus.rd2_row)*COLS + int'(bus.rd2_col)] : 4'h0;
`endif
    e_rd  = exp_word(int'(bus.rd_word));
    acc   = bus.wr_valid && !m_clearing;
    e_err = acc && !coord_ok(int'(bus.wr_row), int'(bus.wr_col));
    if (acc && !e_err) tiles[int'(bus.wr_row)*COLS + int'(bus.wr_col)] = bus.wr_sprite;
    if (m_clearing) begin
      for (int i = 0; i < 8; i++) tiles[m_cnt*8 + i] = m_fill;
      m_cnt++;
      if (m_cnt == NWORDS) m_clearing = 1'b0;
    end else if (bus.clr_start) begin
      m_clearing = 1'b1;
      m_cnt      = 0;
      m_fill     = bus.clr_sprite;
    end
    e_busy = m_clearing;
    @(posedge clk);
    #1;
    check("rd_data",  bus.sprite_addr, e_rd);
    check("wr_err",   32'(bus.wr_err),   32'(e_err));
    check("busy",     32'(bus.busy),     32'(e_busy));
    check("wr_ready", 32'(bus.wr_ready), 32'(!e_busy));
`ifdef TILEMAP_READBACK_EN
    check("rd2_sprite", 32'(bus.rd2_sprite), 32'(e_rd2));
`endif
    if (bus.busy) busy_seen++;
  endtask

  task automatic idle_inputs();
    bus.wr_valid   = 1'b0;
    bus.wr_row     = '0;
    bus.wr_col     = '0;
    bus.wr_sprite  = '0;
    bus.clr_start  = 1'b0;
    bus.clr_sprite = '0;
  endtask

  task automatic write_tile(input int row, input int col, input int spr, output bit acc);
    bus.wr_valid  = 1'b1;
    bus.wr_row    = 6'(row);
    bus.wr_col    = 6'(col);
    bus.wr_sprite = 4'(spr);
    cycle(acc);
    bus.wr_valid  = 1'b0;
  endtask

  task automatic read_word(input int w);
    bit acc;
    bus.rd_word = 8'(w);
    cycle(acc);
  endtask

  task automatic sweep_reads();
    for (int w = 0; w < NWORDS; w++) read_word(w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sprite_addr"}, bus.sprite_addr, 32'h0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    check({tag, "_wr_err"},   32'(bus.wr_err),   32'd0);
  endtask

  initial begin
    bit acc;
    n_cmp     = 0;
    n_bad     = 0;
    busy_seen = 0;
    model_reset();
    idle_inputs();
    bus.rd_word = '0;
`ifdef TILEMAP_READBACK_EN
    bus.rd2_row = '0;
    bus.rd2_col = '0;
`endif

    // Reset state
    rst = 1'b1;
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh map reads zero everywhere, including the out-of-range index 255
    sweep_reads();
    read_word(255);

    // Directed writes: tile 3 and tile 60 (word 7, nibble 4)
    write_tile(0, 3, 5, acc);
    check("wr0_acc", 32'(acc), 32'd1);
    write_tile(1, 0, 10, acc);
    read_word(0);
    check("word0_direct", bus.sprite_addr, 32'h0000_5000);
    read_word(7);
    check("word7_direct", bus.sprite_addr, 32'h000A_0000);

    // Out-of-range writes are accepted, dropped and flagged for one cycle
    write_tile(34, 0, 15, acc);
    check("oor_row_acc", 32'(acc), 32'd1);
    write_tile(0, 60, 15, acc);
    check("oor_col_acc", 32'(acc), 32'd1);
    read_word(0);
    check("word0_after_oor", bus.sprite_addr, 32'h0000_5000);
    read_word(7);
    check("word7_after_oor", bus.sprite_addr, 32'h000A_0000);

    // Randomized writes and reads (some coordinates deliberately out of range)
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_row    = 6'($urandom_range(0, 35));
      bus.wr_col    = 6'($urandom_range(0, 62));
      bus.wr_sprite = 4'($urandom);
      bus.rd_word   = 8'($urandom_range(0, 255));
`ifdef TILEMAP_READBACK_EN
      bus.rd2_row   = 6'($urandom_range(0, 35));
      bus.rd2_col   = 6'($urandom_range(0, 62));
`endif
      cycle(acc);
    end
    idle_inputs();

    // Clear with fill 3; a write held through the clear lands on the first
    // IDLE cycle; a second clr_start mid-clear must be ignored.
    busy_seen      = 0;
    bus.clr_start  = 1'b1;
    bus.clr_sprite = 4'h3;
    cycle(acc);
    bus.clr_start  = 1'b0;
    bus.wr_valid   = 1'b1;
    bus.wr_row     = 6'd2;
    bus.wr_col     = 6'd5;
    bus.wr_sprite  = 4'h7;
    acc = 1'b0;
    for (int i = 0; i < 400 && !acc; i++) begin
      bus.rd_word    = 8'($urandom_range(0, 254));
      bus.clr_start  = (i == 50);
      bus.clr_sprite = (i == 50) ? 4'hC : 4'h3;
      cycle(acc);
    end
    check("held_write_acc", 32'(acc), 32'd1);
    check("busy_cycles", 32'(busy_seen), 32'd255);
    idle_inputs();
    sweep_reads();
    read_word(3);
    check("word3_fill3", bus.sprite_addr, 32'h3333_3333);
    read_word(15);
    check("word15_held_write", bus.sprite_addr, 32'h3373_3333);

    // Reset in the middle of a clear (fill F) after 100 words
    bus.clr_start  = 1'b1;
    bus.clr_sprite = 4'hF;
    cycle(acc);
    bus.clr_start  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.rd_word = 8'($urandom_range(0, 254));
      cycle(acc);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_clear_reset");
    model_reset();
    #2;
    rst = 1'b0;
    sweep_reads();

    // Same-edge write and clear: clear overwrites the written tile
    bus.wr_valid   = 1'b1;
    bus.wr_row     = 6'd0;
    bus.wr_col     = 6'd0;
    bus.wr_sprite  = 4'h9;
    bus.clr_start  = 1'b1;
    bus.clr_sprite = 4'h1;
    bus.rd_word    = 8'd0;
    cycle(acc);
    check("same_edge_acc", 32'(acc), 32'd1);
    idle_inputs();
    for (int i = 0; i < 255; i++) begin
      bus.rd_word = 8'($urandom_range(0, 255));
      cycle(acc);
    end
    read_word(0);
    check("same_edge_word0", bus.sprite_addr, 32'h1111_1111);
    read_word(254);
    check("last_word_fill1", bus.sprite_addr, 32'h1111_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_map_store.md
Name: tile_map_store

Overview:
- Tile-map memory that feeds the pixel generator's tile read interface.
- The pixel generator presents a packed tile-word index (current_tile). This block returns the 32-bit word of eight 4-bit sprite indices (sprite_addr) for that index.
- Game/grid logic writes individual tiles by (row, col) over a valid/ready handshake.
- A built-in clear engine fills the whole map with one sprite index.

Parameters:
- N_PER_ROW, 60, tiles per screen row.
- N_PER_COL, 34, tile rows (33.75 rounded up).
- SPRITE_IDX_W, 4, bits per tile sprite index.
- TILES_PER_WORD, 8, tiles packed per 32-bit word.
- WORD_ADDR_W, 8, width of packed word index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rd_word  in  8  packed word index from pixel generator (current_tile)
- sprite_addr  out  32  packed sprite indices for rd_word; nibble n = tile n of word
- wr_valid  in  1  tile write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_row  in  6  tile row, 0..N_PER_COL-1
- wr_col  in  6  tile column, 0..N_PER_ROW-1
- wr_sprite  in  4  sprite index to store
- wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped
- clr_start  in  1  start full-map clear (pulse)
- clr_sprite  in  4  fill value, sampled on clr_start
- busy  out  1  clear in progress

Behaviour:
- Storage: TILE_WORDS = ceil(N_PER_ROW*N_PER_COL/8) = 255 words of 32 bits.
- Tile addressing: tile_idx = wr_row*N_PER_ROW + wr_col (11 bits).
  - word = tile_idx >> 3
  - nibble = tile_idx[2:0], occupying bits [4*nibble+3 : 4*nibble]
- Reset (async, rst=1), all outputs take these values immediately:
  - all words 0, sprite_addr 0
  - state IDLE, busy 0, wr_ready 1, wr_err 0
- Read port:
  - sprite_addr is registered; data for rd_word at edge k appears after edge k (1-cycle latency).
  - rd_word >= TILE_WORDS returns 0.
  - A read of a word written on the same edge returns the old contents (read-before-write).
- Write handshake:
  - Transfer occurs on a rising edge with wr_valid & wr_ready.
  - Only the addressed nibble changes; the other 7 nibbles are preserved.
  - wr_row >= N_PER_COL or wr_col >= N_PER_ROW: write dropped, wr_err=1 for exactly that next cycle.
  - wr_ready = (state == IDLE).
- FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start. This latches clr_sprite, zeroes clr_cnt and sets busy=1 from the next cycle.
  - In CLEAR, each cycle writes word clr_cnt with the fill nibble replicated 8 times, then clr_cnt++.
  - CLEAR -> IDLE after writing word TILE_WORDS-1. busy falls the cycle after the last write, so a clear takes exactly 255 cycles of busy=1.
  - clr_start while in CLEAR is ignored (no restart, fill value unchanged).
  - wr_valid during CLEAR stalls (wr_ready=0). The requester must hold row/col/sprite stable until accepted.
- Simultaneous wr_valid and clr_start in IDLE: the write is accepted that edge, then clear begins and overwrites it.
- Reset mid-clear: aborts immediately to reset values; the map is all-zero, not partially filled.
- Reads continue during CLEAR. Words already cleared return the fill value; the rest return old data.

Optional Feature:
- Macro: TILEMAP_READBACK_EN.
- Defined:
  - Adds ports rd2_row (6 in), rd2_col (6 in), rd2_sprite (4 out, registered, 1-cycle latency, reset 0) for game logic to inspect a single tile.
  - Out-of-range rd2 coordinates return 0.
  - Uses the same read-before-write rule as the main read port.
- Undefined: these ports do not exist; no extra logic.

Decomposition:
- Package tile_pkg:
  - N_PER_ROW, N_PER_COL, SPRITE_IDX_W, TILES_PER_WORD
  - TILE_WORDS = 255
  - tile_state_t enum {IDLE, CLEAR}
- Sub-module tile_addr_calc (combinational):
  - inputs (row, col); outputs (word[7:0], nibble[2:0], in_range)
  - shared by the write path and the TILEMAP_READBACK_EN port.

Test Plan:
- Reset, then read rd_word 0..254 -> sprite_addr = 0 for all, one cycle after each index.
- Write row=0 col=3 sprite=5 and row=1 col=0 sprite=0xA.
  - Expect rd_word=0 -> 0x0000_5000.
  - Tile 60: word 7, nibble 4. Expect rd_word=7 -> 0x000A_0000.
- Write row=34 col=0, then row=0 col=60 -> each accepted, wr_err pulses one cycle, map unchanged.
- clr_start with clr_sprite=3 -> busy high for 255 cycles, wr_ready=0 throughout; afterwards every word reads 0x3333_3333. A wr_valid held during the clear is accepted on the first IDLE cycle.
- Assert rst at clr_cnt=100 during a clear with fill 0xF -> all outputs 0 immediately; after release all words read 0.
- Same-edge wr_valid and clr_start with fill 0x1, writing row 0 col 0 sprite 9 -> after clear, rd_word=0 reads 0x1111_1111.
